// File: rtl/icache_direct_mapped_pkg.sv
// Shared defaults and FSM state type for the direct-mapped instruction cache.
package icache_direct_mapped_pkg;

  localparam int unsigned ICACHE_LINE_BYTES_LOG = 4;
  localparam int unsigned ICACHE_LINE_NUM_LOG   = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REFILL    = 2'd1,
    ST_WAIT_LAST = 2'd2
  } icache_state_e;

  // Tag width left over once the line offset and the index are removed from a 32-bit pc.
  function automatic int unsigned icache_tag_width(input int unsigned line_bytes_log,
                                                   input int unsigned line_num_log);
    return 32 - line_bytes_log - line_num_log;
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave: the cache itself; master: the fetcher/arbiter/memory environment.
interface icache_direct_mapped_if;

  logic        req_valid;
  logic [31:0] req_pc;
  logic        flush;
  logic [31:0] inst_out;
  logic        valid_out;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_valid;
  logic [7:0]  mem_byte;

  modport master (
    output req_valid, req_pc, flush, mem_gnt, mem_valid, mem_byte,
    input  inst_out, valid_out, mem_en, mem_addr
  );

  modport slave (
    input  req_valid, req_pc, flush, mem_gnt, mem_valid, mem_byte,
    output inst_out, valid_out, mem_en, mem_addr
  );

endinterface

// File: rtl/icache_direct_mapped_tag_array.sv
// Valid bits and tags of the direct-mapped instruction cache.
// Combinational hit lookup, one write port, flush-all.
module icache_tag_array #(
  parameter int unsigned LINE_NUM_LOG = 4,
  parameter int unsigned TAG_W        = 24
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_all,
  input  logic [LINE_NUM_LOG-1:0] rd_index,
  input  logic [TAG_W-1:0]        rd_tag,
  output logic                    hit,
  input  logic                    wr_en,
  input  logic [LINE_NUM_LOG-1:0] wr_index,
  input  logic [TAG_W-1:0]        wr_tag
);

  localparam int unsigned LINES = 1 << LINE_NUM_LOG;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // Valid bits: cleared by reset or flush; set when a refill completes.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag storage needs no reset; the valid bit qualifies it.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  assign hit = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: 1-cycle hits, byte-serial line refill
// through a granted byte-wide memory port, whole-cache flush.
// Optional: ICACHE_STATS_EN enables the hit/miss counters (otherwise tied to 0).
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int unsigned LINE_BYTES_LOG = ICACHE_LINE_BYTES_LOG,
  parameter int unsigned LINE_NUM_LOG   = ICACHE_LINE_NUM_LOG
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  icache_direct_mapped_if.slave  bus,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  localparam int unsigned TAG_W = icache_tag_width(LINE_BYTES_LOG, LINE_NUM_LOG);
  localparam int unsigned AW    = LINE_BYTES_LOG + LINE_NUM_LOG;
  localparam int unsigned DEPTH = 1 << AW;

  icache_state_e state_q, state_d;

  logic [31:LINE_BYTES_LOG]   line_q;      // line base address of the refill
  logic [LINE_BYTES_LOG-1:0]  issue_q;     // next byte offset to request
  logic [LINE_BYTES_LOG-1:0]  inflight_q;  // offset of the granted, not yet returned byte
  logic                       pend_q;      // a granted byte is outstanding

  logic [7:0]  data_q [DEPTH];
  logic [31:0] inst_q;
  logic        valid_q;

  logic [LINE_NUM_LOG-1:0] req_index;
  logic [TAG_W-1:0]        req_tag;
  logic [AW-3:0]           rd_word;
  logic                    hit;

  logic        hit_now;
  logic        start_miss;
  logic        grant;
  logic        fill_done;
  logic        byte_wr;
  logic        mem_en;
  logic [31:0] mem_addr;

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, bus.req_pc[1:0]};

  assign req_index = bus.req_pc[AW-1:LINE_BYTES_LOG];
  assign req_tag   = bus.req_pc[31:AW];
  assign rd_word   = bus.req_pc[AW-1:2];

  icache_tag_array #(
    .LINE_NUM_LOG (LINE_NUM_LOG),
    .TAG_W        (TAG_W)
  ) u_tags (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_all (bus.flush),
    .rd_index  (req_index),
    .rd_tag    (req_tag),
    .hit       (hit),
    .wr_en     (fill_done),
    .wr_index  (line_q[AW-1:LINE_BYTES_LOG]),
    .wr_tag    (line_q[31:AW])
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory request; flush outranks hit, miss and refill progress.
  always_comb begin
    state_d    = state_q;
    mem_en     = 1'b0;
    mem_addr   = '0;
    hit_now    = 1'b0;
    start_miss = 1'b0;
    grant      = 1'b0;
    fill_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          if (hit) begin
            hit_now = 1'b1;
          end else begin
            start_miss = 1'b1;
            state_d    = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        mem_en   = 1'b1;
        mem_addr = {line_q, issue_q};
        grant    = bus.mem_gnt;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (grant && (issue_q == '1)) begin
          state_d = ST_WAIT_LAST;
        end
      end
      ST_WAIT_LAST: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (pend_q && bus.mem_valid) begin
          fill_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_wr      = pend_q && bus.mem_valid && !bus.flush;
  assign bus.mem_en   = mem_en;
  assign bus.mem_addr = mem_addr;

  // Refill bookkeeping: line base, issue pointer, and the single outstanding byte.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_q     <= '0;
      issue_q    <= '0;
      inflight_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (start_miss) begin
        line_q  <= bus.req_pc[31:LINE_BYTES_LOG];
        issue_q <= '0;
      end else if (grant) begin
        issue_q <= issue_q + LINE_BYTES_LOG'(1);
      end
      if (bus.flush) begin
        pend_q <= 1'b0;
      end else if (grant) begin
        pend_q     <= 1'b1;
        inflight_q <= issue_q;
      end else if (bus.mem_valid) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Data array: returned bytes land at the offset latched when they were granted.
  always_ff @(posedge clk_in) begin
    if (byte_wr) begin
      data_q[{line_q[AW-1:LINE_BYTES_LOG], inflight_q}] <= bus.mem_byte;
    end
  end

  // Registered hit response, little-endian word assembly.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
    end else begin
      valid_q <= hit_now;
      if (hit_now) begin
        inst_q <= {data_q[{rd_word, 2'd3}], data_q[{rd_word, 2'd2}],
                   data_q[{rd_word, 2'd1}], data_q[{rd_word, 2'd0}]};
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.inst_out  = inst_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  // Hit/miss statistics, wrapping modulo 2^32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_now)    hit_q  <= hit_q + 32'd1;
      if (start_miss) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: default geometry (dut0) and a
// 4-byte-line, 2-line geometry (dut1). Memory byte at address a is
// a[7:0] ^ {a[11:8], 4'h0}.
module tb_icache_direct_mapped;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit0, miss0, hit1, miss1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          stall_mode  = 1'b0;
  int unsigned gcnt1       = 0;

  icache_direct_mapped_if ifc0 ();
  icache_direct_mapped_if ifc1 ();

  icache_direct_mapped #(.LINE_BYTES_LOG(4), .LINE_NUM_LOG(4)) dut0 (
    .clk_in(clk), .rst_in(rst), .bus(ifc0), .hit_count(hit0), .miss_count(miss0));

  icache_direct_mapped #(.LINE_BYTES_LOG(2), .LINE_NUM_LOG(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .bus(ifc1), .hit_count(hit1), .miss_count(miss1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_of(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], 4'h0};
  endfunction

  // One clock: memory answers next cycle for whatever was granted this cycle.
  task automatic tick();
    logic        g0, g1;
    logic [31:0] a0, a1;
    g0 = ifc0.mem_en && ifc0.mem_gnt;  a0 = ifc0.mem_addr;
    g1 = ifc1.mem_en && ifc1.mem_gnt;  a1 = ifc1.mem_addr;
    @(posedge clk);
    #1;
    ifc0.mem_valid = g0;  ifc0.mem_byte = mem_of(a0);
    ifc1.mem_valid = g1;  ifc1.mem_byte = mem_of(a1);
    if (g1) gcnt1++;
    ifc0.mem_gnt = stall_mode ? ~ifc0.mem_gnt : 1'b1;
    ifc1.mem_gnt = 1'b1;
  endtask

  task automatic set_req(input bit sel, input logic v, input logic [31:0] pc);
    if (sel) begin ifc1.req_valid = v; ifc1.req_pc = pc; end
    else     begin ifc0.req_valid = v; ifc0.req_pc = pc; end
  endtask

  function automatic logic vout(input bit sel);
    return sel ? ifc1.valid_out : ifc0.valid_out;
  endfunction

  function automatic logic [31:0] iout(input bit sel);
    return sel ? ifc1.inst_out : ifc0.inst_out;
  endfunction

  // Request pc and count clocks until valid_out (hit = 1, miss = 2^LB + 3).
  task automatic fetch(input bit sel, input logic [31:0] pc, input logic [31:0] exp_inst,
                       input int unsigned exp_lat, input string tag);
    int unsigned n = 0;
    set_req(sel, 1'b1, pc);
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (vout(sel)) break;
    end
    set_req(sel, 1'b0, pc);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_inst"}, iout(sel), exp_inst);
  endtask

  task automatic check_counts(input string tag, input int unsigned h, input int unsigned m);
`ifdef ICACHE_STATS_EN
    check({tag, "_hits"}, hit0, h);
    check({tag, "_misses"}, miss0, m);
`else
    check({tag, "_hits"}, hit0, 32'd0 & h);
    check({tag, "_misses"}, miss0, 32'd0 & m);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        g;
    int unsigned gb;
    bit          left;

    rst = 1'b1;
    ifc0.req_valid = 1'b0; ifc0.req_pc = '0; ifc0.flush = 1'b0;
    ifc0.mem_gnt = 1'b1;   ifc0.mem_valid = 1'b0; ifc0.mem_byte = '0;
    ifc1.req_valid = 1'b0; ifc1.req_pc = '0; ifc1.flush = 1'b0;
    ifc1.mem_gnt = 1'b1;   ifc1.mem_valid = 1'b0; ifc1.mem_byte = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", ifc0.valid_out, 1'b0);
    check("rst_inst", ifc0.inst_out, 32'h0);
    check("rst_mem_en", ifc0.mem_en, 1'b0);
    check("rst_mem_addr", ifc0.mem_addr, 32'h0);
    check_counts("rst", 0, 0);

    // Cold miss with continuous grant
    set_req(0, 1'b1, 32'h1000);
    tick();
    for (int unsigned i = 0; i < 16; i++) begin
      check("t1_mem_addr", ifc0.mem_addr, 32'h1000 + i);
      tick();
    end
    check("t1_wait_last_en", ifc0.mem_en, 1'b0);
    tick();
    check("t1_no_early_valid", ifc0.valid_out, 1'b0);
    tick();
    check("t1_valid", ifc0.valid_out, 1'b1);
    check("t1_inst", ifc0.inst_out, 32'h03020100);
    set_req(0, 1'b1, 32'h1004);
    tick();
    set_req(0, 1'b0, 32'h1004);
    check("t1_hit_valid", ifc0.valid_out, 1'b1);
    check("t1_hit_inst", ifc0.inst_out, 32'h07060504);
    check_counts("t1", 2, 1);

    // Grant stalls on alternate cycles while refilling 0x2000
    stall_mode = 1'b1;
    ifc0.mem_gnt = 1'b1;
    set_req(0, 1'b1, 32'h2000);
    tick();
    left = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!ifc0.mem_en) begin left = 1'b1; break; end
      a = ifc0.mem_addr;
      g = ifc0.mem_gnt;
      tick();
      if (!g) check("t2_addr_hold", ifc0.mem_addr, a);
    end
    check("t2_refill_done", left, 1'b1);
    stall_mode = 1'b0;
    ifc0.mem_gnt = 1'b1;
    check("t2_last_byte_pending", ifc0.mem_valid, 1'b1);
    check("t2_last_byte", ifc0.mem_byte, 32'h0F);
    tick();
    check("t2_no_early_valid", ifc0.valid_out, 1'b0);
    tick();
    check("t2_w0", ifc0.inst_out, 32'h03020100);
    check("t2_w0_valid", ifc0.valid_out, 1'b1);
    set_req(0, 1'b1, 32'h2004); tick();
    check("t2_w1", ifc0.inst_out, 32'h07060504);
    set_req(0, 1'b1, 32'h2008); tick();
    check("t2_w2", ifc0.inst_out, 32'h0B0A0908);
    set_req(0, 1'b1, 32'h200C); tick();
    set_req(0, 1'b0, 32'h200C);
    check("t2_w3", ifc0.inst_out, 32'h0F0E0D0C);

    // Conflict eviction on index 0
    fetch(0, 32'h1000, 32'h03020100, 19, "t3_a");
    fetch(0, 32'h1100, 32'h13121110, 19, "t3_b");
    fetch(0, 32'h1000, 32'h03020100, 19, "t3_a_again");
    check_counts("t3", 9, 5);

    // Flush in IDLE beats a hit
    fetch(0, 32'h1000, 32'h03020100, 1, "t4_hit");
    set_req(0, 1'b1, 32'h1000);
    ifc0.flush = 1'b1;
    tick();
    ifc0.flush = 1'b0;
    set_req(0, 1'b0, 32'h1000);
    check("t4_flush_valid", ifc0.valid_out, 1'b0);
    check("t4_flush_no_refill", ifc0.mem_en, 1'b0);
    fetch(0, 32'h1000, 32'h03020100, 19, "t4_after_flush");

    // Flush mid-refill at issue pointer 5
    set_req(0, 1'b1, 32'h1040);
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("t4_ptr5_addr", ifc0.mem_addr, 32'h1045);
    set_req(0, 1'b0, 32'h1040);
    ifc0.flush = 1'b1;
    tick();
    ifc0.flush = 1'b0;
    check("t4_abort_en", ifc0.mem_en, 1'b0);
    check("t4_abort_addr", ifc0.mem_addr, 32'h0);
    tick();
    fetch(0, 32'h1040, 32'h43424140, 19, "t4_line_invalid");
    check_counts("t4", 12, 8);

    // Reset mid-refill at byte 7
    set_req(0, 1'b1, 32'h1080);
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("t5_ptr7_addr", ifc0.mem_addr, 32'h1087);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 32'h1080);
    check("t5_stray_present", ifc0.mem_valid, 1'b1);
    check("t5_valid", ifc0.valid_out, 1'b0);
    check("t5_inst", ifc0.inst_out, 32'h0);
    check("t5_mem_en", ifc0.mem_en, 1'b0);
    check("t5_mem_addr", ifc0.mem_addr, 32'h0);
    check_counts("t5_rst", 0, 0);
    tick();
    check("t5_stray_ignored", ifc0.mem_en, 1'b0);
    fetch(0, 32'h1000, 32'h03020100, 19, "t5_cleared");
    fetch(0, 32'h1080, 32'h83828180, 19, "t5_refill");
    check_counts("t5", 2, 2);

    // Small geometry: 4-byte lines, 2 lines
    fetch(1, 32'h0, 32'h03020100, 7, "t6_0");
    fetch(1, 32'h4, 32'h07060504, 7, "t6_4");
    fetch(1, 32'h0, 32'h03020100, 1, "t6_0_hit");
    gb = gcnt1;
    fetch(1, 32'h8, 32'h0B0A0908, 7, "t6_8");
    check("t6_grants", gcnt1 - gb, 32'd4);
    fetch(1, 32'h0, 32'h03020100, 7, "t6_0_evicted");
    fetch(1, 32'h4, 32'h07060504, 1, "t6_4_kept");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
